// File: rtl/apb_timer.sv
// APB down-counting timer: 16-bit prescaler, reloadable 32-bit counter,
// periodic or one-shot expiry with a level interrupt. Zero-wait-state slave.
module apb_timer #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic        pclk,
  input  logic        prstn,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        irq
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PRESC_W = 16;

  localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] OFF_PRESC  = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] OFF_LOAD   = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] OFF_COUNT  = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(32'h10);

  logic                en;
  logic                ie;
  logic                oneshot;
  logic [PRESC_W-1:0]  presc;
  logic [PRESC_W-1:0]  pcnt;
  logic [DATA_W-1:0]   load;
  logic [DATA_W-1:0]   count;
  logic                exp_flag;

  logic [ADDR_W-1:0]   off;
  logic                sel_ctrl;
  logic                sel_presc;
  logic                sel_load;
  logic                sel_count;
  logic                sel_status;
  logic                mapped;
  logic                wr_acc;
  logic                wr_ctrl;
  logic                wr_presc;
  logic                wr_load;
  logic                wr_status;
  logic                tick;
  logic                expire;

  // Upper address bits are decoded by the bridge.
  logic unused_paddr;
  assign unused_paddr = ^paddr[DATA_W-1:ADDR_W];

  // Address decode and write strobes.
  always_comb begin
    off        = paddr[ADDR_W-1:0];
    sel_ctrl   = (off == OFF_CTRL);
    sel_presc  = (off == OFF_PRESC);
    sel_load   = (off == OFF_LOAD);
    sel_count  = (off == OFF_COUNT);
    sel_status = (off == OFF_STATUS);
    mapped     = sel_ctrl | sel_presc | sel_load | sel_count | sel_status;
    wr_acc     = psel & penable & pwrite;
    wr_ctrl    = wr_acc & sel_ctrl;
    wr_presc   = wr_acc & sel_presc;
    wr_load    = wr_acc & sel_load;
    wr_status  = wr_acc & sel_status;
  end

  // A LOAD write or a disabling CTRL write cancels the tick of that cycle.
  always_comb begin
    tick   = en & (pcnt == presc) & ~(wr_ctrl & ~pwdata[0]) & ~wr_load;
    expire = tick & (count == '0);
  end

  always_ff @(posedge pclk) begin
    if (!prstn) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      oneshot  <= 1'b0;
      presc    <= '0;
      pcnt     <= '0;
      load     <= '0;
      count    <= '0;
      exp_flag <= 1'b0;
    end else begin
      if (wr_load || !en || (pcnt == presc) || (wr_ctrl && !pwdata[0])) begin
        pcnt <= '0;
      end else begin
        pcnt <= pcnt + PRESC_W'(1);
      end

      if (wr_ctrl) begin
        {oneshot, ie, en} <= pwdata[2:0];
      end
      // One-shot expiry stops the timer even if CTRL is written in the same cycle.
      if (expire && oneshot) begin
        en <= 1'b0;
      end

      if (wr_presc) begin
        presc <= pwdata[PRESC_W-1:0];
      end

      if (wr_load) begin
        load  <= pwdata;
        count <= pwdata;
      end else if (tick) begin
        count <= (count == '0) ? load : count - DATA_W'(1);
      end

      if (wr_status && pwdata[0]) begin
        exp_flag <= 1'b0;
      end
      if (expire) begin
        exp_flag <= 1'b1;
      end
    end
  end

  // Read mux, live whenever the slave is selected for a read.
  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      if (sel_ctrl)   prdata = DATA_W'({oneshot, ie, en});
      if (sel_presc)  prdata = DATA_W'(presc);
      if (sel_load)   prdata = load;
      if (sel_count)  prdata = count;
      if (sel_status) prdata = DATA_W'(exp_flag);
    end
  end

  assign pslverr = prstn & psel & penable & ~mapped;
  assign irq     = prstn & exp_flag & ie;

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboarded bench for apb_timer: directed register/timing scenarios then
// randomized APB traffic against a behavioural timer model.
module tb_apb_timer;

  localparam int unsigned ADDR_W = 12;

  logic        pclk = 1'b0;
  logic        prstn;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pslverr;
  logic        irq;

  always #5 pclk = ~pclk;

  apb_timer #(.ADDR_W(ADDR_W)) dut (
    .pclk    (pclk),
    .prstn   (prstn),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pslverr (pslverr),
    .irq     (irq)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  logic [11:0] bad_off [4] = '{12'h014, 12'h018, 12'h002, 12'hFFC};

  // Behavioural timer state
  logic        m_en = 1'b0, m_ie = 1'b0, m_os = 1'b0, m_exp = 1'b0;
  logic [15:0] m_presc = '0, m_pcnt = '0;
  logic [31:0] m_load = '0, m_count = '0;

  function automatic exp_t model_out();
    exp_t        e;
    logic [11:0] o;
    logic        mapped;
    o      = paddr[11:0];
    mapped = (o == 12'h000) || (o == 12'h004) || (o == 12'h008) ||
             (o == 12'h00C) || (o == 12'h010);
    e.data = '0;
    if (psel && !pwrite) begin
      case (o)
        12'h000: e.data = {29'd0, m_os, m_ie, m_en};
        12'h004: e.data = {16'd0, m_presc};
        12'h008: e.data = m_load;
        12'h00C: e.data = m_count;
        12'h010: e.data = {31'd0, m_exp};
        default: e.data = '0;
      endcase
    end
    e.err = prstn && psel && penable && !mapped;
    e.irq = prstn && m_exp && m_ie;
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs presented in that cycle.
  task automatic model_step();
    logic [11:0] o;
    logic        wr, cw, lw, tick, os_old;
    logic [15:0] nxt_pcnt;
    if (!prstn) begin
      m_en = 0; m_ie = 0; m_os = 0; m_exp = 0;
      m_presc = '0; m_pcnt = '0; m_load = '0; m_count = '0;
      return;
    end
    o      = paddr[11:0];
    wr     = psel && penable && pwrite;
    cw     = wr && (o == 12'h000);
    lw     = wr && (o == 12'h008);
    tick   = m_en && (m_pcnt == m_presc) && !(cw && !pwdata[0]) && !lw;
    os_old = m_os;
    nxt_pcnt = (!m_en || m_pcnt == m_presc) ? 16'd0 : m_pcnt + 16'd1;
    if (cw && !pwdata[0]) nxt_pcnt = 16'd0;
    if (cw) begin
      m_en = pwdata[0]; m_ie = pwdata[1]; m_os = pwdata[2];
    end
    if (wr && o == 12'h004) m_presc = pwdata[15:0];
    if (wr && o == 12'h010 && pwdata[0]) m_exp = 1'b0;
    if (lw) begin
      m_load = pwdata; m_count = pwdata; nxt_pcnt = 16'd0;
    end else if (tick) begin
      if (m_count != 0) begin
        m_count = m_count - 32'd1;
      end else begin
        m_exp   = 1'b1;
        m_count = m_load;
        if (os_old) m_en = 1'b0;
      end
    end
    m_pcnt = nxt_pcnt;
  endtask

  // One clock: queue the expected outputs of this cycle, then step the model.
  task automatic cycle(input bit ovr, input exp_t ov);
    exp_t e;
    e = model_out();
    if (ovr) e = ov;
    sb_q.push_back(e);
    @(posedge pclk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    exp_t d;
    d.data = '0; d.err = 1'b0; d.irq = 1'b0;
    psel = 1'b0; penable = 1'b0;
    repeat (n) cycle(1'b0, d);
  endtask

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     input bit ovr, input logic [31:0] ed, input bit ee, input bit ei);
    exp_t ov;
    ov.data = ed; ov.err = ee; ov.irq = ei;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    cycle(1'b0, ov);
    penable = 1'b1;
    cycle(ovr, ov);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    apb(1'b1, a, d, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] ed, input bit ei);
    apb(1'b0, a, '0, 1'b1, ed, 1'b0, ei);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s t=%0t paddr=%h act=%h exp=%h", nm, $time, paddr, act, expv);
  endtask

  always @(negedge pclk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("prdata",  prdata,         e.data);
      chk("pslverr", 32'(pslverr),   32'(e.err));
      chk("irq",     32'(irq),       32'(e.irq));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] o;
    logic [31:0] d;
    int unsigned sel;
    prstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    @(posedge pclk);
    #1;
    idle(3);
    prstn = 1'b1;

    // Reset state of every register
    for (int a = 0; a <= 16; a += 4) rd_chk(32'(a), 32'd0, 1'b0);

    // Periodic, PRESC=0 LOAD=3: expiry 4 cycles after the enabling write
    wr(32'h04, 32'd0);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'h3);
    idle(2);
    rd_chk(32'h10, 32'd0, 1'b0);
    rd_chk(32'h10, 32'd1, 1'b1);
    idle(1);
    rd_chk(32'h0C, 32'd3, 1'b1);
    wr(32'h10, 32'd1);
    rd_chk(32'h10, 32'd1, 1'b1);

    // W1C landing on the expiry edge: the set wins
    wr(32'h00, 32'h0);
    wr(32'h10, 32'd1);
    wr(32'h08, 32'd3);
    wr(32'h00, 32'h3);
    idle(2);
    apb(1'b1, 32'h10, 32'd1, 1'b1, 32'd0, 1'b0, 1'b0);
    rd_chk(32'h10, 32'd1, 1'b1);
    wr(32'h00, 32'h2);
    wr(32'h10, 32'd1);
    rd_chk(32'h10, 32'd0, 1'b0);

    // One-shot, PRESC=1 LOAD=2: expiry after 6 cycles, then stopped
    wr(32'h04, 32'd1);
    wr(32'h08, 32'd2);
    wr(32'h00, 32'h7);
    idle(4);
    rd_chk(32'h10, 32'd0, 1'b0);
    rd_chk(32'h10, 32'd1, 1'b1);
    rd_chk(32'h00, 32'h6, 1'b1);
    rd_chk(32'h0C, 32'd2, 1'b1);
    idle(10);
    rd_chk(32'h0C, 32'd2, 1'b1);

    // Unmapped offset: read and write both error, nothing changes
    apb(1'b0, 32'h18, 32'd0, 1'b1, 32'd0, 1'b1, 1'b1);
    apb(1'b1, 32'h18, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, 1'b1);
    rd_chk(32'h00, 32'h6, 1'b1);
    rd_chk(32'h04, 32'd1, 1'b1);
    rd_chk(32'h08, 32'd2, 1'b1);
    rd_chk(32'h0C, 32'd2, 1'b1);
    rd_chk(32'h10, 32'd1, 1'b1);

    // Reset mid-count aborts everything
    wr(32'h10, 32'd1);
    wr(32'h04, 32'h100);
    wr(32'h08, 32'h10);
    wr(32'h00, 32'h3);
    idle(5);
    rd_chk(32'h0C, 32'h10, 1'b0);
    prstn = 1'b0;
    idle(1);
    prstn = 1'b1;
    for (int a = 0; a <= 16; a += 4) rd_chk(32'(a), 32'd0, 1'b0);
    idle(40);
    rd_chk(32'h0C, 32'd0, 1'b0);
    rd_chk(32'h10, 32'd0, 1'b0);
    rd_chk(32'h00, 32'd0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: o = 12'h000;
        1: o = 12'h004;
        2: o = 12'h008;
        3: o = 12'h00C;
        4: o = 12'h010;
        default: o = bad_off[$urandom_range(0, 3)];
      endcase
      d = $urandom;
      if (o == 12'h004) d = (d & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
      if (o == 12'h008) d = 32'($urandom_range(0, 6));
      if (o == 12'h000) d[0] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 2) prstn = 1'b0;
      apb($urandom_range(0, 1) == 1, ($urandom & 32'hFFFF_F000) | 32'(o), d,
          1'b0, '0, 1'b0, 1'b0);
      prstn = 1'b1;
      idle($urandom_range(0, 3));
    end

    idle(2);
    checks++;
    if (sb_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/apb_timer.md
APB_TIMER -- requirements
Module: apb_timer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, number of low paddr bits decoded locally; higher bits are decoded upstream by the bridge.
REQ-002 SHALL have port pclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port prstn  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port paddr  input  32  APB address; only bits [ADDR_W-1:0] are used.
REQ-005 SHALL have port psel  input  1  slave select from the bridge.
REQ-006 SHALL have port penable  input  1  APB access phase.
REQ-007 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port pwdata  input  32  write data.
REQ-009 SHALL have port prdata  output  32  read data.
REQ-010 SHALL have port pslverr  output  1  error response for an unmapped offset.
REQ-011 SHALL have port irq  output  1  level interrupt to the system irq vector.

Function
REQ-012 SHALL be zero-wait-state (no pready): a write commits on the pclk edge where psel & penable & pwrite = 1.
REQ-013 SHALL drive prdata combinationally from the decoded register when psel=1 & pwrite=0, and drive it to 0 otherwise.
REQ-014 SHALL provide this register map (word access, offset = paddr[ADDR_W-1:0]):
  - 0x00 CTRL RW: [0] EN, [1] IE, [2] ONESHOT, others 0.
  - 0x04 PRESC RW: [15:0].
  - 0x08 LOAD RW: [31:0].
  - 0x0C COUNT RO: writes ignored.
  - 0x10 STATUS: [0] EXP, write-1-to-clear.
REQ-015 SHALL, for any other offset, return prdata = 0, ignore writes, and assert pslverr = psel & penable; pslverr SHALL be 0 in all other cases.
REQ-016 SHALL keep a 16-bit prescaler counter pcnt; while EN=1, pcnt increments each cycle, and when pcnt == PRESC it generates a one-cycle tick and wraps to 0.
REQ-017 SHALL hold pcnt at 0 and generate no tick while EN=0.
REQ-018 SHALL, on tick with COUNT != 0, decrement COUNT by 1.
REQ-019 SHALL, on tick with COUNT == 0, set EXP, reload COUNT = LOAD, and also clear EN if ONESHOT=1.
REQ-020 SHALL, on a LOAD write, also set COUNT = pwdata and pcnt = 0; this overrides any tick in the same cycle.
REQ-021 SHALL, on a CTRL write with EN=0, suppress any tick in that cycle.
REQ-022 SHALL, on a CTRL write that changes EN from 0 to 1, start pcnt from 0.
REQ-023 SHALL give EXP priority over a same-cycle W1C: the set wins.
REQ-024 SHALL produce the first expiry (L+1)*(P+1) cycles after the enabling write edge, where LOAD=L and PRESC=P, and then every (L+1)*(P+1) cycles in periodic mode.
REQ-025 SHALL drive irq = EXP & IE as a registered-state level; clearing EXP or IE deasserts irq in the same cycle as the register change.
REQ-026 SHALL treat LOAD=0 as a tick-rate period: expiry on every tick.

Reset
REQ-027 SHALL, when prstn=0 at a pclk edge, set CTRL, PRESC, LOAD, COUNT, STATUS and pcnt to 0, regardless of any APB access in that cycle.
REQ-028 SHALL hold irq=0 and pslverr=0 during reset, with prdata=0 unless psel & read.
REQ-029 SHALL abort any count in progress on reset mid-operation; counting resumes only after software re-enables the timer.

Verification
REQ-030 SHALL be tested with reset applied, then reads of 0x00-0x10 -> all return 0, irq=0, pslverr=0.
REQ-031 SHALL be tested with PRESC=0, LOAD=3, CTRL=0x3 -> EXP=1 and irq=1 exactly 4 cycles after the CTRL write edge, COUNT reads 3, and re-expiry occurs every 4 cycles.
REQ-032 SHALL be tested with PRESC=1, LOAD=2, CTRL=0x7 -> EXP set 6 cycles after the write, CTRL reads 0x6, COUNT stays 2 with no further ticks.
REQ-033 SHALL be tested with a W1C of STATUS=0x1 on the same cycle as an expiry -> EXP reads 1 and irq stays high; a later W1C -> EXP=0 and irq=0.
REQ-034 SHALL be tested with a read of 0x18 and a write of 0xFFFFFFFF to 0x18 -> prdata=0, pslverr=1 in the access phase, and all registers unchanged.
REQ-035 SHALL be tested with prstn=0 for one cycle while COUNT=0x10 with EN=1 -> all registers read 0 and no tick or irq occurs afterward.
